// File: rtl/bit_serial_adder_pkg.sv
// bit_serial_adder_pkg: shared FSM state encoding for the bit-serial adder
package bit_serial_adder_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/bit_serial_adder_fa.sv
// full_adaar_dataflow: single-bit combinational full-adder cell
module full_adaar_dataflow (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cy
);
    assign s  = a ^ b ^ c;
    assign cy = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds a+b+cin one bit per clock, LSB first, through one full-adder cell
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry_q, s, cy, last;

    full_adaar_dataflow u_fa (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .c (carry_q),
        .s (s),
        .cy(cy)
    );

    // Shift-based insert keeps WIDTH=1 legal (no empty part-select).
    assign sum_nx   = (sum_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign last     = cnt == CW'(WIDTH - 1);
    assign in_ready = state == S_IDLE;
    assign busy     = state == S_RUN || state == S_DONE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:  state_nx = in_valid  ? S_RUN  : S_IDLE;
            S_RUN:   state_nx = last      ? S_DONE : S_RUN;
            S_DONE:  state_nx = out_ready ? S_IDLE : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                a_sh    <= a;
                b_sh    <= b;
                carry_q <= cin;
                cnt     <= '0;
            end
            if (state == S_RUN) begin
                sum_sh  <= sum_nx;
                carry_q <= cy;
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                cnt     <= cnt + 1'b1;
                if (last) begin
                    sum       <= sum_nx;
                    cout      <= cy;
                    out_valid <= 1'b1;
                end
            end
            if (state == S_DONE && out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule
